eth_tx_sched: RTL and testbench

Transmit scheduler in front of the RMII transmitter, which holds a payload FIFO and a frame FSM. Two payload sources share that transmitter. The block arbitrates between them round-robin, streams the granted payload into the transmitter's byte FIFO, and zero-pads short payloads. It then fires the packet-ready strobe, tracks the frame on the wire via Tx_En, and enforces the inter-packet gap before the next grant.

---
 rtl/eth_tx_sched_pkg.sv | 20 ++
 rtl/eth_tx_sched_rr_arb2.sv | 29 ++
 rtl/eth_tx_sched.sv | 153 +++++++++++++++
 tb/tb_eth_tx_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_sched_pkg.sv
// rtl/eth_tx_sched_pkg.sv - shared state encodings, length width and parameter defaults
package eth_tx_sched_pkg;

  localparam int LEN_W           = 11;
  localparam int IPG_CYCLES_DEF  = 48;
  localparam int MIN_PAYLOAD_DEF = 46;
  localparam int MAX_PAYLOAD_DEF = 1500;

  typedef enum logic [2:0] {
    SCH_IDLE     = 3'd0,
    SCH_GRANT    = 3'd1,
    SCH_LOAD     = 3'd2,
    SCH_PAD      = 3'd3,
    SCH_START    = 3'd4,
    SCH_WAIT_ON  = 3'd5,
    SCH_WAIT_OFF = 3'd6,
    SCH_IPG      = 3'd7
  } sch_state_e;

endpackage

// File: rtl/eth_tx_sched_rr_arb2.sv
// rtl/eth_tx_sched_rr_arb2.sv - 2-way round-robin arbiter, source 0 favoured out of reset
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Req_i,
  input  logic       Upd_i,
  input  logic [1:0] Last_i,
  output logic [1:0] Win_o
);

  logic fav1_q, fav1_d;

  // A win by source 0 hands the next tie to source 1, and vice versa.
  always_comb begin
    fav1_d = fav1_q;
    if (Upd_i) fav1_d = (Last_i == 2'b01);
  end

  always_ff @(posedge Clk) begin
    if (Rst) fav1_q <= 1'b0;
    else     fav1_q <= fav1_d;
  end

  always_comb begin
    Win_o = Req_i;
    if (&Req_i) Win_o = fav1_q ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - two-source transmit scheduler feeding the RMII transmitter FIFO
// ETH_TX_SCHED_PAD_EN builds the PAD state; otherwise short payloads are dropped.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int pIPG_CYCLES  = IPG_CYCLES_DEF,
  parameter int pMIN_PAYLOAD = MIN_PAYLOAD_DEF,
  parameter int pMAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Req,
  input  logic [LEN_W-1:0] Req_Len_0,
  input  logic [LEN_W-1:0] Req_Len_1,
  output logic [1:0]       Gnt,
  input  logic [7:0]       Src_Byte_0,
  input  logic [7:0]       Src_Byte_1,
  input  logic [1:0]       Src_Valid,
  output logic [1:0]       Src_Rdy,
  output logic [7:0]       Eth_Byte,
  output logic             Eth_Byte_Valid,
  output logic             Eth_Pkt_Rdy,
  input  logic             Tx_En,
  output logic [1:0]       Done,
  output logic [1:0]       Drop,
  output logic             Busy
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(pMIN_PAYLOAD);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(pMAX_PAYLOAD);
  localparam logic [LEN_W-1:0] IPG_L = LEN_W'(pIPG_CYCLES - 1);

  sch_state_e       state_q, state_d;
  logic [1:0]       gnt_q, win;
  logic [LEN_W-1:0] len_sel, len_q, cnt_q;
  logic             len_bad, xfer;
  logic [7:0]       src_byte;

  rr_arb2 u_arb (
    .Clk    (Clk),
    .Rst    (Rst),
    .Req_i  (Req),
    .Upd_i  (state_q == SCH_GRANT),
    .Last_i (gnt_q),
    .Win_o  (win)
  );

  assign Gnt      = gnt_q;
  assign len_sel  = gnt_q[1] ? Req_Len_1 : Req_Len_0;
  assign src_byte = gnt_q[1] ? Src_Byte_1 : Src_Byte_0;
  assign xfer     = |(Src_Valid & Src_Rdy);

`ifdef ETH_TX_SCHED_PAD_EN
  logic need_pad;
  assign len_bad  = (len_sel == '0) || (len_sel > MAX_L);
  assign need_pad = (len_q < MIN_L);
`else
  assign len_bad  = (len_sel == '0) || (len_sel > MAX_L) || (len_sel < MIN_L);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= SCH_IDLE;
    else     state_q <= state_d;
  end

  // LOAD lingers one cycle at count == Len so the start strobe trails the last write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCH_IDLE:     if (|Req) state_d = SCH_GRANT;
      SCH_GRANT:    state_d = len_bad ? SCH_IDLE : SCH_LOAD;
      SCH_LOAD: begin
        if (cnt_q == len_q) begin
`ifdef ETH_TX_SCHED_PAD_EN
          state_d = need_pad ? SCH_PAD : SCH_START;
`else
          state_d = SCH_START;
`endif
        end
      end
`ifdef ETH_TX_SCHED_PAD_EN
      SCH_PAD:      if (cnt_q == MIN_L) state_d = SCH_START;
`endif
      SCH_START:    state_d = SCH_WAIT_ON;
      SCH_WAIT_ON:  if (Tx_En) state_d = SCH_WAIT_OFF;
      SCH_WAIT_OFF: if (!Tx_En) state_d = SCH_IPG;
      SCH_IPG:      if (cnt_q == IPG_L) state_d = SCH_IDLE;
      default:      state_d = SCH_IDLE;
    endcase
  end

  always_comb begin
    Src_Rdy     = 2'b00;
    Eth_Pkt_Rdy = 1'b0;
    Busy        = (state_q != SCH_IDLE);
    if (state_q == SCH_LOAD && cnt_q != len_q) Src_Rdy = gnt_q;
    if (state_q == SCH_START) Eth_Pkt_Rdy = 1'b1;
  end

  // The byte counter doubles as the IPG counter once the frame is off the wire.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      gnt_q          <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      Eth_Byte       <= '0;
      Eth_Byte_Valid <= 1'b0;
      Done           <= '0;
      Drop           <= '0;
    end else begin
      Eth_Byte_Valid <= 1'b0;
      Done           <= '0;
      Drop           <= '0;
      case (state_q)
        SCH_IDLE: if (|Req) gnt_q <= win;
        SCH_GRANT: begin
          len_q <= len_sel;
          cnt_q <= '0;
          if (len_bad) begin
            Drop  <= gnt_q;
            gnt_q <= '0;
          end
        end
        SCH_LOAD: begin
          if (xfer) begin
            Eth_Byte       <= src_byte;
            Eth_Byte_Valid <= 1'b1;
            cnt_q          <= cnt_q + LEN_W'(1);
          end
        end
`ifdef ETH_TX_SCHED_PAD_EN
        SCH_PAD: begin
          if (cnt_q != MIN_L) begin
            Eth_Byte       <= 8'h00;
            Eth_Byte_Valid <= 1'b1;
            cnt_q          <= cnt_q + LEN_W'(1);
          end
        end
`endif
        SCH_WAIT_OFF: begin
          if (!Tx_En) begin
            Done  <= gnt_q;
            gnt_q <= '0;
            cnt_q <= '0;
          end
        end
        SCH_IPG: cnt_q <= cnt_q + LEN_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - scoreboard bench for eth_tx_sched against a frame-level model
module tb_eth_tx_sched;

  localparam int IPG  = 48;
  localparam int MINP = 46;
  localparam int MAXP = 1500;

  logic        Clk = 1'b0, Rst = 1'b1;
  logic [1:0]  Req = '0, Src_Valid = '0;
  logic [10:0] Req_Len_0 = '0, Req_Len_1 = '0;
  logic [7:0]  Src_Byte_0 = '0, Src_Byte_1 = '0;
  logic        Tx_En = 1'b0;
  logic [1:0]  Gnt, Src_Rdy, Done, Drop;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid, Eth_Pkt_Rdy, Busy;

  eth_tx_sched dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_Len_0(Req_Len_0), .Req_Len_1(Req_Len_1),
    .Gnt(Gnt), .Src_Byte_0(Src_Byte_0), .Src_Byte_1(Src_Byte_1), .Src_Valid(Src_Valid),
    .Src_Rdy(Src_Rdy), .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid),
    .Eth_Pkt_Rdy(Eth_Pkt_Rdy), .Tx_En(Tx_En), .Done(Done), .Drop(Drop), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { int src_len; int total; } frm_t;

  int          checks = 0, errors = 0;
  int          lens0[$], lens1[$];
  logic [7:0]  d0[$], d1[$];
  logic [7:0]  exp_bytes[$];
  logic [1:0]  exp_gnt[$];
  logic [3:0]  exp_evt[$];
  frm_t        exp_frames[$];
  bit          m_fav1 = 1'b0;
  bit          vmode = 1'b1;

  function automatic bit bad_len(input int len);
`ifdef ETH_TX_SCHED_PAD_EN
    return (len == 0) || (len > MAXP);
`else
    return (len == 0) || (len > MAXP) || (len < MINP);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_frame(input int s, input int len, input bit incr);
    logic [7:0] b;
    if (s == 0) lens0.push_back(len); else lens1.push_back(len);
    if (!bad_len(len)) begin
      for (int k = 0; k < len; k++) begin
        b = incr ? 8'(k) : 8'($urandom);
        if (s == 0) d0.push_back(b); else d1.push_back(b);
      end
    end
  endtask

  // Frame-level model: round-robin order over pending requests, then the expected writes.
  task automatic plan();
    int   i0, i1, o0, o1, s, len, tot;
    frm_t f;
    i0 = 0; i1 = 0; o0 = 0; o1 = 0;
    while (i0 < lens0.size() || i1 < lens1.size()) begin
      if (i0 < lens0.size() && i1 < lens1.size()) s = m_fav1 ? 1 : 0;
      else s = (i0 < lens0.size()) ? 0 : 1;
      m_fav1 = (s == 0);
      len = (s == 0) ? lens0[i0] : lens1[i1];
      if (s == 0) i0++; else i1++;
      exp_gnt.push_back(2'(1 << s));
      if (bad_len(len)) begin
        exp_evt.push_back(4'(4 << s));
      end else begin
        for (int k = 0; k < len; k++) exp_bytes.push_back((s == 0) ? d0[o0 + k] : d1[o1 + k]);
        if (s == 0) o0 += len; else o1 += len;
        tot = len;
        while (tot < MINP) begin
          exp_bytes.push_back(8'h00);
          tot++;
        end
        f.src_len = len;
        f.total   = tot;
        exp_frames.push_back(f);
        exp_evt.push_back(4'(1 << s));
      end
    end
  endtask

  task automatic flush_all();
    lens0.delete(); lens1.delete(); d0.delete(); d1.delete();
    exp_bytes.delete(); exp_gnt.delete(); exp_evt.delete(); exp_frames.delete();
  endtask

  task automatic do_reset();
    @(posedge Clk); #2;
    Rst = 1'b1;
    flush_all();
    m_fav1 = 1'b0;
    @(posedge Clk); #3;
    chk("rst_gnt", Gnt, 0);
    chk("rst_src_rdy", Src_Rdy, 0);
    chk("rst_eth_byte", Eth_Byte, 0);
    chk("rst_eth_valid", Eth_Byte_Valid, 0);
    chk("rst_pkt_rdy", Eth_Pkt_Rdy, 0);
    chk("rst_done", Done, 0);
    chk("rst_drop", Drop, 0);
    chk("rst_busy", Busy, 0);
    Rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #2;
      n++;
    end while (n < budget && (Busy || Req != 0 || lens0.size() != 0 || lens1.size() != 0 ||
               exp_gnt.size() != 0 || exp_bytes.size() != 0 || exp_evt.size() != 0 ||
               exp_frames.size() != 0));
    chk("phase_drained_in_budget", int'(n < budget), 1);
    if (n >= budget) flush_all();
  endtask

  // Source driver: requests, lengths and byte streams from the per-source queues.
  initial begin
    logic [1:0] x, pg;
    pg = '0;
    forever begin
      @(negedge Clk);
      x = Src_Valid & Src_Rdy;
      @(posedge Clk); #1;
      if (Rst) begin
        pg = '0; Req = '0; Src_Valid = '0;
        continue;
      end
      if (x[0] && d0.size() != 0) void'(d0.pop_front());
      if (x[1] && d1.size() != 0) void'(d1.pop_front());
      if (pg[0] && !Gnt[0] && lens0.size() != 0) void'(lens0.pop_front());
      if (pg[1] && !Gnt[1] && lens1.size() != 0) void'(lens1.pop_front());
      pg = Gnt;
      Req[0]       = (lens0.size() != 0);
      Req[1]       = (lens1.size() != 0);
      Req_Len_0    = (lens0.size() != 0) ? 11'(lens0[0]) : 11'd0;
      Req_Len_1    = (lens1.size() != 0) ? 11'(lens1[0]) : 11'd0;
      Src_Valid[0] = (d0.size() != 0) && (vmode || $urandom_range(0, 2) != 0);
      Src_Valid[1] = (d1.size() != 0) && (vmode || $urandom_range(0, 2) != 0);
      Src_Byte_0   = (d0.size() != 0) ? d0[0] : 8'h00;
      Src_Byte_1   = (d1.size() != 0) ? d1[0] : 8'h00;
    end
  end

  // Transmitter stand-in: frame goes on the wire a few cycles after the start strobe.
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (!Rst && Eth_Pkt_Rdy) begin
        repeat ($urandom_range(1, 4)) @(posedge Clk);
        #1 Tx_En = 1'b1;
        repeat ($urandom_range(4, 16)) @(posedge Clk);
        #1 Tx_En = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    logic [1:0] pg, px;
    logic       pv, ptx, pptx;
    bit         padding;
    int         n, wr, done_n;
    frm_t       f;
    pg = '0; px = '0; pv = 1'b0; ptx = 1'b0; pptx = 1'b0;
    n = 0; wr = 0; done_n = -1;
    forever begin
      @(negedge Clk);
      n++;
      if (Rst) begin
        pg = '0; px = '0; pv = 1'b0; ptx = 1'b0; pptx = 1'b0; wr = 0; done_n = -1;
        continue;
      end
      if ((Src_Rdy & ~Gnt) != 0) chk("rdy_only_for_granted", Src_Rdy, Src_Rdy & Gnt);
      if (Gnt != pg && pg == 0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", Gnt, 0);
        else chk("gnt_order", Gnt, exp_gnt.pop_front());
        if (done_n >= 0) chk("ipg_before_next_gnt", int'((n - done_n) >= IPG + 1), 1);
      end else if (Gnt != pg && Gnt != 0) begin
        chk("gnt_released_before_next", Gnt, 0);
      end
      if (Eth_Byte_Valid) begin
        padding = (exp_frames.size() != 0) && (wr >= exp_frames[0].src_len);
        if (!padding) chk("write_follows_xfer", int'(px != 0), 1);
        if (exp_bytes.size() == 0) chk("byte_unexpected", Eth_Byte_Valid, 0);
        else chk("eth_byte", Eth_Byte, exp_bytes.pop_front());
        wr++;
      end else if (px != 0) begin
        chk("write_after_xfer", Eth_Byte_Valid, 1);
      end
      if (Eth_Pkt_Rdy) begin
        chk("pkt_rdy_after_last_write", {pv, Eth_Byte_Valid}, 2);
        if (exp_frames.size() == 0) begin
          chk("pkt_rdy_unexpected", Eth_Pkt_Rdy, 0);
        end else begin
          f = exp_frames.pop_front();
          chk("frame_write_count", wr, f.total);
        end
        wr = 0;
      end
      if ((Done | Drop) != 0) begin
        if (exp_evt.size() == 0) chk("done_drop_unexpected", {Drop, Done}, 0);
        else chk("done_drop", {Drop, Done}, exp_evt.pop_front());
        if (Done != 0) begin
          chk("done_after_tx_fall", {pptx, ptx}, 2);
          done_n = n;
        end
      end
      pg = Gnt; px = Src_Valid & Src_Rdy; pv = Eth_Byte_Valid; pptx = ptx; ptx = Tx_En;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();

    vmode = 1'b1;
    add_frame(0, 64, 1'b1);
    add_frame(0, 50, 1'b0);
    plan();
    wait_idle(4000);

    do_reset();
    add_frame(0, 50, 1'b0);
    add_frame(0, 50, 1'b0);
    add_frame(1, 50, 1'b0);
    plan();
    wait_idle(5000);

    vmode = 1'b0;
    add_frame(1, 10, 1'b0);
    plan();
    wait_idle(2000);

    add_frame(0, 0, 1'b0);
    add_frame(0, 1501, 1'b0);
    add_frame(0, 1500, 1'b0);
    add_frame(1, 46, 1'b0);
    add_frame(1, 45, 1'b0);
    plan();
    wait_idle(12000);

    for (int r = 0; r < 6; r++) add_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 120)), 1'b0);
    plan();
    wait_idle(8000);

    do_reset();
    add_frame(0, 200, 1'b0);
    plan();
    n = 0;
    while (d0.size() > 180 && n < 2000) begin
      @(posedge Clk); #2;
      n++;
    end
    chk("load_progress_before_rst", int'(n < 2000), 1);
    do_reset();
    add_frame(0, 50, 1'b0);
    add_frame(1, 50, 1'b0);
    plan();
    wait_idle(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
